// File: rtl/dump_pkg.sv
// dump_pkg: encodings shared by state_dump_engine, the CPU top and the bench.
//   ST_*    : readout FSM state encodings
//   SRC_*   : out_src encodings (register / memory beat)
//   max_u   : helper for derived widths
package dump_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REG  = 2'd1;
    localparam logic [1:0] ST_MEM  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    localparam logic SRC_REG = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dump_out_slot.sv
// dump_out_slot: one-entry valid/ready output register.
//   load        in  : capture in_* this cycle (only legal while slot_free_c)
//   in_*        in  : beat payload to capture
//   out_ready   in  : downstream accept
//   slot_free_c out : combinational, slot can take a new beat this cycle
//   out_*       out : registered beat presented downstream
module dump_out_slot #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_src,
    input  logic [IDX_W-1:0]      in_index,
    input  logic                  out_ready,
    output logic                  slot_free_c,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_src,
    output logic [IDX_W-1:0]      out_index
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  src_q,   src_d;
    logic [IDX_W-1:0]      index_q, index_d;

    assign slot_free_c = !valid_q || out_ready;

    // Payload only changes on a load, so it is stable while stalled.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        index_d = index_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            src_d   = in_src;
            index_d = in_index;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= 1'b0;
            index_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
            index_q <= index_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign out_index = index_q;

endmodule

// File: rtl/state_dump_engine.sv
// state_dump_engine: freezes the CPU and streams register-file and/or a
// data-memory window out over a valid/ready port.
//   start/mode/mem_base/mem_count in : dump request, sampled in IDLE
//   busy, halt_req                out : high whenever not IDLE
//   done                          out : one-cycle completion pulse
//   rf_raddr/rf_rdata                 : register file spare read port
//   dm_raddr/dm_rdata                 : data memory spare read port
//   out_valid/out_ready/out_*         : beat stream (data, source, index)
module state_dump_engine
    import dump_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_DEPTH  = 32,
    parameter int unsigned MEM_DEPTH  = 32,
    parameter int unsigned SKIP_X0    = 0,
    localparam int unsigned RF_AW     = $clog2(REG_DEPTH),
    localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH),
    localparam int unsigned IDX_W     = max_u(RF_AW, MEM_AW)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [MEM_AW-1:0]     mem_base,
    input  logic [MEM_AW:0]       mem_count,
    output logic                  busy,
    output logic                  halt_req,
    output logic                  done,
    output logic [RF_AW-1:0]      rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic [MEM_AW-1:0]     dm_raddr,
    input  logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_src,
    output logic [IDX_W-1:0]      out_index
);

    localparam logic [MEM_AW:0]  MEM_DEPTH_W = (MEM_AW+1)'(MEM_DEPTH);
    localparam logic [IDX_W-1:0] REG_LAST    = IDX_W'(REG_DEPTH - 1);

    logic [1:0]        state_q,  state_d;
    logic              mem_en_q, mem_en_d;
    logic [MEM_AW-1:0] base_q,   base_d;
    logic [MEM_AW:0]   count_q,  count_d;
    logic [IDX_W-1:0]  cnt_q,    cnt_d;
    logic              done_q,   done_d;

    logic                  slot_free_c;
    logic                  load_c;
    logic [DATA_WIDTH-1:0] cap_data_c;
    logic                  cap_src_c;
    logic [IDX_W-1:0]      cap_index_c;

    logic [MEM_AW:0]   count_clamped_c;
    logic [MEM_AW-1:0] mem_addr_c;
    logic              mem_last_c;

    assign count_clamped_c = (mem_count > MEM_DEPTH_W) ? MEM_DEPTH_W : mem_count;
    // MEM_AW-bit sum wraps naturally at MEM_DEPTH.
    assign mem_addr_c      = base_q + cnt_q[MEM_AW-1:0];
    assign mem_last_c      = ((MEM_AW+1)'(cnt_q[MEM_AW-1:0]) + (MEM_AW+1)'(1)) == count_q;

    // Next-state, counter and capture control.
    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        base_d      = base_q;
        count_d     = count_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        load_c      = 1'b0;
        cap_data_c  = '0;
        cap_src_c   = SRC_REG;
        cap_index_c = '0;
        case (state_q)
            ST_IDLE: begin
                if (start && (mode != 2'b00)) begin
                    mem_en_d = mode[1];
                    base_d   = mem_base;
                    count_d  = count_clamped_c;
                    cnt_d    = IDX_W'(SKIP_X0);
                    if (mode[0])                    state_d = ST_REG;
                    else if (count_clamped_c == '0) state_d = ST_FIN;
                    else                            state_d = ST_MEM;
                end
            end
            ST_REG: begin
                if (slot_free_c) begin
                    load_c      = 1'b1;
                    cap_data_c  = rf_rdata;
                    cap_src_c   = SRC_REG;
                    cap_index_c = cnt_q;
                    if (cnt_q == REG_LAST) begin
                        cnt_d   = '0;
                        state_d = (mem_en_q && (count_q != '0)) ? ST_MEM : ST_FIN;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_MEM: begin
                if (slot_free_c) begin
                    load_c      = 1'b1;
                    cap_data_c  = dm_rdata;
                    cap_src_c   = SRC_MEM;
                    cap_index_c = IDX_W'(mem_addr_c);
                    if (mem_last_c) begin
                        cnt_d   = '0;
                        state_d = ST_FIN;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_FIN: begin
                // Wait for the last beat to drain before signalling completion.
                if (slot_free_c) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mem_en_q <= 1'b0;
            base_q   <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_en_q <= mem_en_d;
            base_q   <= base_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    dump_out_slot #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .load        (load_c),
        .in_data     (cap_data_c),
        .in_src      (cap_src_c),
        .in_index    (cap_index_c),
        .out_ready   (out_ready),
        .slot_free_c (slot_free_c),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_src     (out_src),
        .out_index   (out_index)
    );

    assign busy     = (state_q != ST_IDLE);
    assign halt_req = busy;
    assign done     = done_q;
    assign rf_raddr = (state_q == ST_REG) ? cnt_q[RF_AW-1:0] : '0;
    assign dm_raddr = (state_q == ST_MEM) ? mem_addr_c : '0;

endmodule
